// File: rtl/wb_reg_bridge_pkg.sv
// Shared types and helpers for the Wishbone-to-register-bus bridge.
// The lane helpers walk the selected byte lanes of a 32-bit access in ascending order.
package wb_reg_bridge_pkg;

  localparam int unsigned LANES = 4;
  localparam logic [11:0] BASE_HI_DEFAULT = 12'hFF0;

  typedef enum logic [2:0] {
    StIdle,
    StWrLane,
    StRdIssue,
    StRdCapt,
    StAck,
    StWaitDrop
  } state_e;

  typedef struct packed {
    logic [1:0] lane;
    logic       last;
  } lane_step_t;

  function automatic logic [1:0] first_lane(input logic [LANES-1:0] sel);
    logic [1:0] r;
    r = '0;
    for (int i = LANES - 1; i >= 0; i--) begin
      if (sel[i]) r = 2'(i);
    end
    return r;
  endfunction

  // last=1 when no selected lane lies above the current one.
  function automatic lane_step_t next_lane(input logic [LANES-1:0] sel, input logic [1:0] lane);
    lane_step_t r;
    r.lane = lane;
    r.last = 1'b1;
    for (int i = LANES - 1; i >= 0; i--) begin
      if (i > int'(lane) && sel[i]) begin
        r.lane = 2'(i);
        r.last = 1'b0;
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/wb_reg_bridge.sv
// Wishbone classic responder for the crypto register window: serialises each selected byte
// lane into one register-bus transfer and shares the register bus with the USB front end.
module wb_reg_bridge
  import wb_reg_bridge_pkg::*;
#(
  parameter int unsigned pADDR_WIDTH   = 21,
  parameter int unsigned pBYTECNT_SIZE = 7,
  parameter logic [11:0] pBASE_HI      = BASE_HI_DEFAULT
) (
  input  logic                               clk_i,
  input  logic                               reset_i,
  input  logic [31:0]                        wb_adr_i,
  input  logic [31:0]                        wb_dat_i,
  input  logic [3:0]                         wb_sel_i,
  input  logic                               wb_we_i,
  input  logic                               wb_stb_i,
  input  logic                               wb_cyc_i,
  output logic [31:0]                        wb_dat_o,
  output logic                               wb_ack_o,
  output logic                               wb_err_o,
  input  logic [pADDR_WIDTH-pBYTECNT_SIZE-1:0] usb_address_i,
  input  logic [pBYTECNT_SIZE-1:0]           usb_bytecnt_i,
  input  logic                               usb_read_i,
  input  logic                               usb_write_i,
  input  logic [7:0]                         usb_wdata_i,
  input  logic                               usb_busy_i,
  output logic [pADDR_WIDTH-pBYTECNT_SIZE-1:0] reg_address_o,
  output logic [pBYTECNT_SIZE-1:0]           reg_bytecnt_o,
  output logic                               reg_read_o,
  output logic                               reg_write_o,
  output logic [7:0]                         reg_wdata_o,
  input  logic [7:0]                         reg_rdata_i,
  output logic                               bridge_active_o,
  output logic                               usb_drop_o
);

  state_e                   state_q, state_d;
  logic [1:0]               lane_q, lane_d;
  logic [pADDR_WIDTH-1:0]   adr_q, adr_d;
  logic [31:0]              dat_q, dat_d;
  logic [3:0]               sel_q, sel_d;
  logic [31:0]              rdat_q, rdat_d;
  logic                     err_q, err_d;
  logic                     start;
  lane_step_t               step;

  // The USB front end keeps the bus whenever it is mid-transfer or strobing this cycle.
  assign start = wb_cyc_i & wb_stb_i & ~usb_busy_i & ~usb_read_i & ~usb_write_i;
  assign step  = next_lane(sel_q, lane_q);

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q <= StIdle;
      lane_q  <= '0;
      adr_q   <= '0;
      dat_q   <= '0;
      sel_q   <= '0;
      rdat_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      lane_q  <= lane_d;
      adr_q   <= adr_d;
      dat_q   <= dat_d;
      sel_q   <= sel_d;
      rdat_q  <= rdat_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    lane_d  = lane_q;
    adr_d   = adr_q;
    dat_d   = dat_q;
    sel_d   = sel_q;
    rdat_d  = rdat_q;
    err_d   = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          adr_d  = wb_adr_i[pADDR_WIDTH-1:0];
          dat_d  = wb_dat_i;
          sel_d  = wb_sel_i;
          rdat_d = '0;
          lane_d = first_lane(wb_sel_i);
          if (wb_adr_i[31:20] != pBASE_HI) begin
            err_d   = 1'b1;
            state_d = StWaitDrop;
          end else if (wb_sel_i == 4'b0000) begin
            state_d = StAck;
          end else begin
            state_d = wb_we_i ? StWrLane : StRdIssue;
          end
        end
      end
      StWrLane: begin
        if (!wb_cyc_i)      state_d = StIdle;
        else if (step.last) state_d = StAck;
        else                lane_d  = step.lane;
      end
      StRdIssue: begin
        state_d = wb_cyc_i ? StRdCapt : StIdle;
      end
      StRdCapt: begin
        if (!wb_cyc_i) begin
          state_d = StIdle;
        end else begin
          rdat_d[{lane_q, 3'b000} +: 8] = reg_rdata_i;
          if (step.last) begin
            state_d = StAck;
          end else begin
            lane_d  = step.lane;
            state_d = StRdIssue;
          end
        end
      end
      StAck: state_d = StWaitDrop;
      StWaitDrop: begin
        if (!wb_stb_i || !wb_cyc_i) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  assign bridge_active_o = (state_q != StIdle);
  assign wb_ack_o        = (state_q == StAck);
  assign wb_err_o        = err_q;
  assign wb_dat_o        = rdat_q;
  assign usb_drop_o      = bridge_active_o & (usb_read_i | usb_write_i);

  always_comb begin
    reg_address_o = usb_address_i;
    reg_bytecnt_o = usb_bytecnt_i;
    reg_read_o    = usb_read_i;
    reg_write_o   = usb_write_i;
    reg_wdata_o   = usb_wdata_i;
    if (bridge_active_o) begin
      reg_address_o = adr_q[pADDR_WIDTH-1:pBYTECNT_SIZE];
      reg_bytecnt_o = adr_q[pBYTECNT_SIZE-1:0] + pBYTECNT_SIZE'(lane_q);
      reg_wdata_o   = dat_q[{lane_q, 3'b000} +: 8];
      // Strobes are withheld in the cycle the master abandons the transfer.
      reg_read_o    = (state_q == StRdIssue) & wb_cyc_i;
      reg_write_o   = (state_q == StWrLane) & wb_cyc_i;
    end
  end

endmodule

// File: tb/tb_wb_reg_bridge.sv
// Directed self-checking bench for wb_reg_bridge: Wishbone writes/reads, address miss,
// empty select, USB arbitration, abort and asynchronous reset.
module tb_wb_reg_bridge;

  logic        clk = 1'b0;
  logic        reset_i;
  logic [31:0] wb_adr_i, wb_dat_i, wb_dat_o;
  logic [3:0]  wb_sel_i;
  logic        wb_we_i, wb_stb_i, wb_cyc_i, wb_ack_o, wb_err_o;
  logic [13:0] usb_address_i, reg_address_o;
  logic [6:0]  usb_bytecnt_i, reg_bytecnt_o;
  logic        usb_read_i, usb_write_i, usb_busy_i;
  logic [7:0]  usb_wdata_i, reg_wdata_o, reg_rdata_i;
  logic        reg_read_o, reg_write_o, bridge_active_o, usb_drop_o;

  always #5 clk = ~clk;

  wb_reg_bridge dut (
    .clk_i           (clk),
    .reset_i         (reset_i),
    .wb_adr_i        (wb_adr_i),
    .wb_dat_i        (wb_dat_i),
    .wb_sel_i        (wb_sel_i),
    .wb_we_i         (wb_we_i),
    .wb_stb_i        (wb_stb_i),
    .wb_cyc_i        (wb_cyc_i),
    .wb_dat_o        (wb_dat_o),
    .wb_ack_o        (wb_ack_o),
    .wb_err_o        (wb_err_o),
    .usb_address_i   (usb_address_i),
    .usb_bytecnt_i   (usb_bytecnt_i),
    .usb_read_i      (usb_read_i),
    .usb_write_i     (usb_write_i),
    .usb_wdata_i     (usb_wdata_i),
    .usb_busy_i      (usb_busy_i),
    .reg_address_o   (reg_address_o),
    .reg_bytecnt_o   (reg_bytecnt_o),
    .reg_read_o      (reg_read_o),
    .reg_write_o     (reg_write_o),
    .reg_wdata_o     (reg_wdata_o),
    .reg_rdata_i     (reg_rdata_i),
    .bridge_active_o (bridge_active_o),
    .usb_drop_o      (usb_drop_o)
  );

  // Bus monitor and register-block read responder, sampled on the inactive edge.
  localparam logic [31:0] RdWord = 32'h4433_2211;
  int          cyc_cnt = 0, nrd = 0, nack = 0, nerr = 0, ndrop = 0, ack_cyc = 0;
  logic [31:0] ack_dat = '0, rd_log = '0;
  logic [31:0] wr_q[$];
  logic        rd_pend = 1'b0;
  logic [1:0]  rd_idx = '0;

  initial reg_rdata_i = 8'hEE;

  always @(negedge clk) begin
    cyc_cnt <= cyc_cnt + 1;
    if (reg_write_o) wr_q.push_back({3'b000, reg_address_o, reg_bytecnt_o, reg_wdata_o});
    if (reg_read_o) begin
      nrd    <= nrd + 1;
      rd_log <= {rd_log[23:0], 1'b0, reg_bytecnt_o};
    end
    if (wb_ack_o) begin
      nack    <= nack + 1;
      ack_cyc <= cyc_cnt + 1;
      ack_dat <= wb_dat_o;
    end
    if (wb_err_o)   nerr  <= nerr + 1;
    if (usb_drop_o) ndrop <= ndrop + 1;
    rd_pend <= reg_read_o;
    if (rd_pend) begin
      reg_rdata_i <= RdWord[{rd_idx, 3'b000} +: 8];
      rd_idx      <= rd_idx + 2'd1;
    end else begin
      reg_rdata_i <= 8'hEE;
    end
  end

  int vec = 0, miss = 0;
  int ack_b, err_b, rd_b, drop_b, wr_b, s;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vec++;
    assert (obs === exp)
    else begin
      miss++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic mark();
    ack_b = nack; err_b = nerr; rd_b = nrd; drop_b = ndrop; wr_b = wr_q.size();
  endtask

  task automatic wb_start(input logic [31:0] adr, input logic [31:0] dat,
                          input logic [3:0] sel, input logic we);
    @(posedge clk); #2;
    wb_adr_i = adr; wb_dat_i = dat; wb_sel_i = sel; wb_we_i = we;
    wb_cyc_i = 1'b1; wb_stb_i = 1'b1;
  endtask

  // Wait for ack or err within budget cycles, keep the strobe up for hold more cycles, release.
  task automatic wait_term(input int budget, input int hold);
    int  k;
    logic got;
    k = 0;
    got = 1'b0;
    while (!got && k < budget) begin
      @(negedge clk); #1;
      k++;
      got = (nack != ack_b) || (nerr != err_b);
    end
    check("terminated", 32'(got), 32'd1);
    repeat (hold) @(posedge clk);
    @(posedge clk); #2;
    wb_cyc_i = 1'b0; wb_stb_i = 1'b0;
    repeat (2) @(negedge clk);
    #1;
  endtask

  initial begin
    reset_i = 1'b1;
    wb_adr_i = '0; wb_dat_i = '0; wb_sel_i = '0; wb_we_i = 1'b0;
    wb_stb_i = 1'b0; wb_cyc_i = 1'b0;
    usb_address_i = 14'h1555; usb_bytecnt_i = 7'h2A; usb_read_i = 1'b0;
    usb_write_i = 1'b0; usb_wdata_i = 8'hC3; usb_busy_i = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    check("rst_ack", 32'(wb_ack_o), 32'd0);
    check("rst_err", 32'(wb_err_o), 32'd0);
    check("rst_dat", wb_dat_o, 32'd0);
    check("rst_active", 32'(bridge_active_o), 32'd0);
    check("rst_drop", 32'(usb_drop_o), 32'd0);
    @(posedge clk); #2;
    reset_i = 1'b0;
    @(negedge clk); #1;
    check("pass_addr", 32'(reg_address_o), 32'h1555);
    check("pass_bc", 32'(reg_bytecnt_o), 32'h2A);
    check("pass_wdata", 32'(reg_wdata_o), 32'hC3);

    // Single-lane write; strobe held after ack must not be serviced twice.
    mark();
    wb_start(32'hFF00_0104, 32'h0000_00A5, 4'b0001, 1'b1);
    s = cyc_cnt + 1;
    wait_term(20, 3);
    check("w1_nack", 32'(nack - ack_b), 32'd1);
    check("w1_lat", 32'(ack_cyc - s), 32'd2);
    check("w1_nwr", 32'(wr_q.size() - wr_b), 32'd1);
    check("w1_entry", wr_q[wr_b], 32'h0001_04A5);
    check("w1_nrd", 32'(nrd - rd_b), 32'd0);

    // Four-lane read.
    mark();
    wb_start(32'hFF00_0100, 32'h0, 4'b1111, 1'b0);
    s = cyc_cnt + 1;
    wait_term(30, 0);
    check("r4_lat", 32'(ack_cyc - s), 32'd9);
    check("r4_dat", ack_dat, 32'h4433_2211);
    check("r4_hold", wb_dat_o, 32'h4433_2211);
    check("r4_bc", rd_log, 32'h0001_0203);
    check("r4_nrd", 32'(nrd - rd_b), 32'd4);
    check("r4_nwr", 32'(wr_q.size() - wr_b), 32'd0);

    // Sparse write with bytecnt wrap.
    mark();
    wb_start(32'hFF00_007F, 32'hDEAD_BEEF, 4'b1010, 1'b1);
    s = cyc_cnt + 1;
    wait_term(20, 0);
    check("wsp_lat", 32'(ack_cyc - s), 32'd3);
    check("wsp_nwr", 32'(wr_q.size() - wr_b), 32'd2);
    check("wsp_e0", wr_q[wr_b], 32'h0000_00BE);
    check("wsp_e1", wr_q[wr_b + 1], 32'h0000_02DE);
    check("wsp_nrd", 32'(nrd - rd_b), 32'd0);

    // Address miss.
    mark();
    wb_start(32'h1234_0000, 32'h0, 4'b1111, 1'b0);
    wait_term(10, 2);
    check("miss_nerr", 32'(nerr - err_b), 32'd1);
    check("miss_nack", 32'(nack - ack_b), 32'd0);
    check("miss_nrd", 32'(nrd - rd_b), 32'd0);
    check("miss_nwr", 32'(wr_q.size() - wr_b), 32'd0);

    // Empty byte select.
    mark();
    wb_start(32'hFF00_0000, 32'h0, 4'b0000, 1'b0);
    s = cyc_cnt + 1;
    wait_term(10, 0);
    check("sel0_nack", 32'(nack - ack_b), 32'd1);
    check("sel0_lat", 32'(ack_cyc - s), 32'd1);
    check("sel0_dat", ack_dat, 32'd0);
    check("sel0_nrd", 32'(nrd - rd_b), 32'd0);

    // USB busy at request time: USB write goes through, bridge waits.
    mark();
    wb_start(32'hFF00_0104, 32'h0000_0077, 4'b0001, 1'b1);
    usb_busy_i = 1'b1; usb_write_i = 1'b1; usb_address_i = 14'h0033;
    usb_bytecnt_i = 7'h11; usb_wdata_i = 8'h5A;
    @(negedge clk); #1;
    check("busy_wr", 32'(reg_write_o), 32'd1);
    check("busy_wdata", 32'(reg_wdata_o), 32'h5A);
    check("busy_active", 32'(bridge_active_o), 32'd0);
    @(posedge clk); #2;
    usb_write_i = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    check("busy_wait", 32'(bridge_active_o), 32'd0);
    @(posedge clk); #2;
    usb_busy_i = 1'b0;
    wait_term(20, 0);
    check("busy_nwr", 32'(wr_q.size() - wr_b), 32'd2);
    check("busy_e0", wr_q[wr_b], 32'h0019_915A);
    check("busy_e1", wr_q[wr_b + 1], 32'h0001_0477);

    // USB write while the bridge is reading.
    mark();
    wb_start(32'hFF00_0100, 32'h0, 4'b1111, 1'b0);
    repeat (3) @(posedge clk);
    #2;
    usb_write_i = 1'b1; usb_address_i = 14'h003F;
    @(negedge clk); #1;
    check("drop_pulse", 32'(usb_drop_o), 32'd1);
    check("drop_blk", 32'(reg_write_o), 32'd0);
    check("drop_active", 32'(bridge_active_o), 32'd1);
    @(posedge clk); #2;
    usb_write_i = 1'b0;
    wait_term(30, 0);
    check("drop_n", 32'(ndrop - drop_b), 32'd1);
    check("drop_nwr", 32'(wr_q.size() - wr_b), 32'd0);
    check("drop_dat", ack_dat, 32'h4433_2211);

    // Master abandons a read in the capture cycle.
    mark();
    wb_start(32'hFF00_0100, 32'h0, 4'b0001, 1'b0);
    repeat (2) @(posedge clk);
    #2;
    wb_cyc_i = 1'b0; wb_stb_i = 1'b0;
    repeat (6) @(negedge clk);
    #1;
    check("abort_nack", 32'(nack - ack_b), 32'd0);
    check("abort_active", 32'(bridge_active_o), 32'd0);
    check("abort_nrd", 32'(nrd - rd_b), 32'd1);

    // Reset in the middle of a four-lane write.
    mark();
    wb_start(32'hFF00_0100, 32'h4433_2211, 4'b1111, 1'b1);
    repeat (2) @(posedge clk);
    #2;
    reset_i = 1'b1;
    #1;
    check("rrst_ack", 32'(wb_ack_o), 32'd0);
    check("rrst_err", 32'(wb_err_o), 32'd0);
    check("rrst_active", 32'(bridge_active_o), 32'd0);
    check("rrst_dat", wb_dat_o, 32'd0);
    check("rrst_wr", 32'(reg_write_o), 32'd0);
    check("rrst_addr", 32'(reg_address_o), 32'h003F);
    wb_cyc_i = 1'b0; wb_stb_i = 1'b0;
    @(posedge clk); #2;
    reset_i = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    check("rrst_nack", 32'(nack - ack_b), 32'd0);
    check("rrst_nwr", 32'(wr_q.size() - wr_b), 32'd1);
    check("rrst_e0", wr_q[wr_b], 32'h0001_0011);

    // Normal operation afterwards.
    mark();
    wb_start(32'hFF00_0104, 32'h0000_005C, 4'b0001, 1'b1);
    s = cyc_cnt + 1;
    wait_term(20, 0);
    check("post_lat", 32'(ack_cyc - s), 32'd2);
    check("post_nwr", 32'(wr_q.size() - wr_b), 32'd1);
    check("post_e0", wr_q[wr_b], 32'h0001_045C);

    $display("== %0d vectors applied, %0d miscompares ==", vec, miss);
    $finish;
  end

endmodule

// File: doc/wb_reg_bridge.md
Name: wb_reg_bridge

Overview:
Wishbone classic responder that terminates NEO430 bus cycles aimed at the crypto register window and converts them into the byte-wide register-bus strobes consumed by the AES register block. It replaces the current combinational mux and immediate-ack shortcut. Each selected byte lane of a 32-bit access is serialised into one register-bus transfer, and read bytes are gathered into wb_dat_o. The block arbitrates the register bus against the USB front end and sits between neo430_top_wrapper, cw305_usb_reg_fe and cw305_reg_aes in crypt_clk domain.

Parameters:
pADDR_WIDTH, 21, register-bus full address width
pBYTECNT_SIZE, 7, byte-count field width
pBASE_HI, 12'hFF0, required value of wb_adr_i[31:20] for a hit

Ports:
clk_i  in  1  crypt_clk
reset_i  in  1  asynchronous, active-high reset
wb_adr_i  in  32  Wishbone address
wb_dat_i  in  32  Wishbone write data
wb_sel_i  in  4  byte-lane selects
wb_we_i  in  1  write enable
wb_stb_i  in  1  strobe
wb_cyc_i  in  1  cycle
wb_dat_o  out  32  read data, valid with wb_ack_o
wb_ack_o  out  1  one-cycle acknowledge
wb_err_o  out  1  one-cycle error (address miss)
usb_address_i  in  pADDR_WIDTH-pBYTECNT_SIZE  USB front-end address
usb_bytecnt_i  in  pBYTECNT_SIZE  USB byte count
usb_read_i  in  1  USB read strobe
usb_write_i  in  1  USB write strobe
usb_wdata_i  in  8  USB write data
usb_busy_i  in  1  USB address phase active (reg_addrvalid)
reg_address_o  out  pADDR_WIDTH-pBYTECNT_SIZE  to register block
reg_bytecnt_o  out  pBYTECNT_SIZE  to register block
reg_read_o  out  1  read strobe
reg_write_o  out  1  write strobe
reg_wdata_o  out  8  write data
reg_rdata_i  in  8  register read data, valid one cycle after reg_read_o
bridge_active_o  out  1  bridge owns the register bus
usb_drop_o  out  1  one-cycle pulse: USB strobe ignored while bridge active

Behaviour:
- Reset: FSM=IDLE; wb_dat_o=0, wb_ack_o=0, wb_err_o=0, bridge_active_o=0, usb_drop_o=0; reg_* outputs follow the USB pass-through.
- States: IDLE, WR_LANE, RD_ISSUE, RD_CAPT, ACK, WAIT_DROP.
- IDLE: reg_* = usb_* combinationally. Start when cyc&stb&!usb_busy_i. Latch adr, dat, sel, we.
  - Address miss (adr[31:20]!=pBASE_HI): wb_err_o pulses next cycle, then WAIT_DROP; no register traffic.
  - sel==0: ACK with wb_dat_o=0; no register traffic.
  - Otherwise, lane pointer = lowest selected lane; go to WR_LANE or RD_ISSUE.
- Lane addressing:
  - reg_address_o = adr[pADDR_WIDTH-1:pBYTECNT_SIZE].
  - reg_bytecnt_o = adr[pBYTECNT_SIZE-1:0] + lane, modulo 2^pBYTECNT_SIZE; wrap is silent.
- WR_LANE: reg_write_o=1 for one cycle, reg_wdata_o = dat byte[lane]. Advance to the next selected lane (ascending); after the last lane go to ACK.
- RD_ISSUE: reg_read_o=1 for one cycle. RD_CAPT: capture reg_rdata_i into wb_dat_o byte[lane], then advance or go to ACK. Unselected lanes read 0.
- Latency: writes take N+1 cycles, reads 2N+1 cycles, from start to ack, where N = number of selected lanes.
- ACK: wb_ack_o=1 for exactly one cycle, then WAIT_DROP. wb_dat_o holds until the next start.
- WAIT_DROP: return to IDLE when stb=0 or cyc=0, so a held strobe is never serviced twice.
- cyc deasserted in WR_LANE/RD_*: abort to IDLE, no ack. Writes already issued stand.
- bridge_active_o=1 in every state except IDLE. While active, usb_read_i/usb_write_i are blocked and each such strobe pulses usb_drop_o.
- Simultaneous USB strobe and Wishbone start in IDLE: USB wins; the bridge waits while usb_busy_i=1.
- reset_i mid-transaction: immediate return to reset values; the pending cycle is never acked.

Decomposition:
- Package wb_reg_bridge_pkg:
  - state enum
  - LANES=4
  - default pBASE_HI
  - function next_lane(sel, lane) returning the next set bit and a last flag
- Single module, no sub-module; the lane sequencer is too small to split.

Test Plan:
- Write adr=0xFF00_0104, sel=4'b0001, dat=0x0000_00A5 -> one reg_write, address=0x02, bytecnt=0x04, wdata=0xA5; ack 2 cycles after start.
- Read adr=0xFF00_0100, sel=4'b1111, reg_rdata returns 0x11,0x22,0x33,0x44 -> bytecnt 0..3 in order, wb_dat_o=0x4433_2211, ack at cycle 9.
- Write sel=4'b1010, dat=0xDEAD_BEEF, adr low bits 0x7F -> writes 0xBE at bytecnt 0x00 (wrap) and 0xDE at bytecnt 0x02; no other strobes.
- Access adr=0x1234_0000 -> wb_err_o one pulse, no reg_read/reg_write; sel=0 -> ack, dat_o=0.
- usb_busy_i high when stb rises -> bridge waits, USB write passes through; USB write during active bridge read -> usb_drop_o pulse, USB write not forwarded.
- cyc dropped in RD_CAPT, and separately reset_i during WR_LANE -> no ack; all outputs return to reset values; next access works normally.
